// File: rtl/read_path_pkg.sv
// Shared constants and the sequencer state type for the read word-line path.
package read_path_pkg;

    localparam int NUM_ROWS = 4;
    localparam int ADDR_W   = 2;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        WL   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/read_wl_ctrl_if.sv
// Request/response bundle between a read requester and read_wl_ctrl.
// A request is taken on a rising edge where rd_req && rd_ready; rd_valid marks
// the single cycle in which rd_data is new, and the response has no backpressure.
interface read_wl_ctrl_if #(
    parameter int DATA_W = 1
);
    import read_path_pkg::*;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ready,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ready,
        output rd_data,
        output rd_valid
    );

endinterface

// File: rtl/rwl_decoder.sv
// Registered one-hot row decoder; word lines change only on clock edges.
module rwl_decoder
    import read_path_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [NUM_ROWS-1:0] rwl_o
);

    localparam logic [NUM_ROWS-1:0] ROW0 = {{(NUM_ROWS-1){1'b0}}, 1'b1};

    logic [NUM_ROWS-1:0] rwl_q;
    logic [NUM_ROWS-1:0] rwl_d;

    // Clear wins over enable so a word line can never linger into IDLE.
    always_comb begin
        rwl_d = rwl_q;
        if (clr_i) begin
            rwl_d = '0;
        end else if (en_i) begin
            rwl_d = ROW0 << addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rwl_q <= '0;
        end else begin
            rwl_q <= rwl_d;
        end
    end

    assign rwl_o = rwl_q;

endmodule

// File: rtl/read_wl_ctrl.sv
// Read sequencer for the 4-row read_mux: precharge phase, one word-line phase,
// then capture of DOUT with a one-cycle valid pulse.
module read_wl_ctrl
    import read_path_pkg::*;
#(
    parameter int DATA_W     = 1,
    parameter int PRE_CYCLES = 1,
    parameter int WL_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    read_wl_ctrl_if.slave     bus,
    output logic              precharge,
    output logic              rwl_0,
    output logic              rwl_1,
    output logic              rwl_2,
    output logic              rwl_3,
    input  logic [DATA_W-1:0] dout_in,
    output rd_state_e         dbg_state_o
);

    if (PRE_CYCLES < 1 || PRE_CYCLES > CNT_MAX) begin : g_bad_pre
        $error("read_wl_ctrl: PRE_CYCLES out of range 1..15");
    end
    if (WL_CYCLES < 1 || WL_CYCLES > CNT_MAX) begin : g_bad_wl
        $error("read_wl_ctrl: WL_CYCLES out of range 1..15");
    end

    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);

    rd_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                pre_q, pre_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                wl_set;
    logic                wl_clr;
    logic [NUM_ROWS-1:0] rwl_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            pre_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            pre_q   <= pre_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        pre_d   = pre_q;
        data_d  = data_q;
        valid_d = 1'b0;
        wl_set  = 1'b0;
        wl_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rd_req) begin
                    addr_d  = bus.rd_addr;
                    cnt_d   = PRE_LOAD;
                    pre_d   = 1'b1;
                    state_d = PRE;
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    pre_d   = 1'b0;
                    wl_set  = 1'b1;
                    cnt_d   = WL_LOAD;
                    state_d = WL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WL: begin
                // dout_in only matters here, on the last word-line edge.
                if (cnt_q == '0) begin
                    data_d  = dout_in;
                    valid_d = 1'b1;
                    wl_clr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                pre_d   = 1'b0;
                wl_clr  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.rd_ready = (state_q == IDLE);
        bus.rd_data  = data_q;
        bus.rd_valid = valid_q;
        precharge    = pre_q;
        dbg_state_o  = state_q;
    end

    rwl_decoder u_rwl_decoder (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (wl_set),
        .clr_i  (wl_clr),
        .addr_i (addr_q),
        .rwl_o  (rwl_vec)
    );

    assign rwl_0 = rwl_vec[0];
    assign rwl_1 = rwl_vec[1];
    assign rwl_2 = rwl_vec[2];
    assign rwl_3 = rwl_vec[3];

    a_rwl_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rwl_vec));
    a_rwl_not_pre: assert property (@(posedge clk) disable iff (!rst_n)
        !(pre_q && (rwl_vec != '0)));
    a_rwl_only_wl: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != WL) |-> (rwl_vec == '0));

endmodule

// File: tb/tb_read_wl_ctrl.sv
// Bench for read_wl_ctrl: a default instance (1/1) and a 3/2 instance, a
// cycle-level reference model, a directed vector table and random traffic.
module tb_read_wl_ctrl;
    import read_path_pkg::*;

    localparam int DW = 1;
    localparam int PA = 1;
    localparam int WA = 1;
    localparam int PB = 3;
    localparam int WB = 2;

    // k = edges since the accept edge, -1 when idle; k == p+w is the valid cycle.
    typedef struct packed {
        int          k;
        logic [1:0]  addr;
        logic [DW-1:0] data;
    } mdl_t;

    typedef struct {
        logic          req;
        logic [1:0]    addr;
        logic          ready;
        logic          pre;
        logic [3:0]    rwl;
        logic          valid;
        logic [DW-1:0] data;
    } vec_t;

    localparam mdl_t MDL_RST = '{k: -1, addr: 2'b00, data: '0};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    read_wl_ctrl_if #(.DATA_W(DW)) bus_a ();
    read_wl_ctrl_if #(.DATA_W(DW)) bus_b ();

    logic          pre_a, pre_b;
    logic [3:0]    rwl_a, rwl_b;
    logic [DW-1:0] dout_a, dout_b;
    logic [DW-1:0] rows [4];
    rd_state_e     st_a, st_b;

    int n_checks = 0;
    int n_fail   = 0;
    int reads_done = 0;
    logic chk_en = 1'b0;
    logic [DW-1:0] exp_q [$];
    mdl_t ma, mb;

    read_wl_ctrl #(.DATA_W(DW), .PRE_CYCLES(PA), .WL_CYCLES(WA)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .precharge(pre_a),
        .rwl_0(rwl_a[0]), .rwl_1(rwl_a[1]), .rwl_2(rwl_a[2]), .rwl_3(rwl_a[3]),
        .dout_in(dout_a), .dbg_state_o(st_a)
    );

    read_wl_ctrl #(.DATA_W(DW), .PRE_CYCLES(PB), .WL_CYCLES(WB)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .precharge(pre_b),
        .rwl_0(rwl_b[0]), .rwl_1(rwl_b[1]), .rwl_2(rwl_b[2]), .rwl_3(rwl_b[3]),
        .dout_in(dout_b), .dbg_state_o(st_b)
    );

    // read_mux stand-in: DOUT is the row selected by the active word line.
    always_comb begin
        dout_a = '0;
        dout_b = '0;
        for (int i = 0; i < 4; i++) begin
            if (rwl_a[i]) dout_a = dout_a | rows[i];
            if (rwl_b[i]) dout_b = dout_b | rows[i];
        end
    end

    function automatic mdl_t mdl_step(input mdl_t m, input int p, input int w,
                                      input logic req, input logic [1:0] addr,
                                      input logic [DW-1:0] sampled);
        mdl_t n;
        n = m;
        if ((m.k < 0) || (m.k == p + w)) begin
            n.k = req ? 0 : -1;
            if (req) n.addr = addr;
        end else begin
            n.k = m.k + 1;
            if (n.k == p + w) n.data = sampled;
        end
        return n;
    endfunction

    // {ready, precharge, rwl[3:0], valid, data}
    function automatic logic [6+DW:0] mdl_out(input mdl_t m, input int p, input int w);
        logic [3:0] rwl;
        rwl = ((m.k >= p) && (m.k < p + w)) ? (4'b0001 << m.addr) : 4'b0000;
        return {(m.k < 0) || (m.k == p + w), (m.k >= 0) && (m.k < p), rwl,
                m.k == p + w, m.data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= MDL_RST;
            mb <= MDL_RST;
        end else begin
            ma <= mdl_step(ma, PA, WA, bus_a.rd_req, bus_a.rd_addr, rows[ma.addr]);
            mb <= mdl_step(mb, PB, WB, bus_b.rd_req, bus_b.rd_addr, rows[mb.addr]);
            if (ma.k == PA + WA - 1) exp_q.push_back(rows[ma.addr]);
        end
    end

    // Every-cycle comparison of both instances against the model, plus the data scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_cycle", 32'({bus_a.rd_ready, pre_a, rwl_a, bus_a.rd_valid, bus_a.rd_data}),
                  32'(mdl_out(ma, PA, WA)));
            check("b_cycle", 32'({bus_b.rd_ready, pre_b, rwl_b, bus_b.rd_valid, bus_b.rd_data}),
                  32'(mdl_out(mb, PB, WB)));
            check("a_rwl_onehot0", 32'($onehot0(rwl_a)), 32'd1);
            check("b_pre_excl", 32'(pre_b && (rwl_b != 4'b0)), 32'd0);
            if (bus_a.rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_a_empty: got rd_valid=1 expected no pending read at %0t", $time);
                end else begin
                    check("sb_a_data", 32'(bus_a.rd_data), 32'(exp_q.pop_front()));
                    reads_done++;
                end
            end
        end
    end

    vec_t tbl [14];

    initial begin
        // req addr ready pre rwl valid data (rows preset 1,1,0,1)
        tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'd1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 2'd3, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 2'd3, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};

        bus_a.rd_req = 1'b0; bus_a.rd_addr = 2'd0;
        bus_b.rd_req = 1'b0; bus_b.rd_addr = 2'd0;
        rows = '{1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_vec_a", 32'({bus_a.rd_ready, pre_a, rwl_a, bus_a.rd_valid, bus_a.rd_data}), 32'h80);
        check("rst_vec_b", 32'({bus_b.rd_ready, pre_b, rwl_b, bus_b.rd_valid, bus_b.rd_data}), 32'h80);
        check("rst_state_a", 32'(st_a), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Single access to row 0, then back-to-back rows 1, 2, 3
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check($sformatf("tbl_%0d", i),
                  32'({bus_a.rd_ready, pre_a, rwl_a, bus_a.rd_valid, bus_a.rd_data}),
                  32'({tbl[i].ready, tbl[i].pre, tbl[i].rwl, tbl[i].valid, tbl[i].data}));
            bus_a.rd_req  = tbl[i].req;
            bus_a.rd_addr = tbl[i].addr;
        end

        // Long precharge / word-line instance, row 2
        @(negedge clk);
        bus_b.rd_req = 1'b1; bus_b.rd_addr = 2'd2;
        @(negedge clk);
        bus_b.rd_req = 1'b0; bus_b.rd_addr = 2'd0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t3_pre_k%0d", k), 32'(pre_b), 32'(k < 3));
            check($sformatf("t3_rwl_k%0d", k), 32'(rwl_b), (k == 3 || k == 4) ? 32'h4 : 32'h0);
            check($sformatf("t3_valid_k%0d", k), 32'(bus_b.rd_valid), 32'(k == 5));
            if (k < 5) @(negedge clk);
        end
        check("t3_data", 32'(bus_b.rd_data), 32'd0);

        // Request pulse during PRE is dropped
        @(negedge clk);
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 2'd1;
        @(negedge clk);
        check("t4_ready_pre", 32'(bus_a.rd_ready), 32'd0);
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 2'd3;
        @(negedge clk);
        bus_a.rd_req = 1'b0; bus_a.rd_addr = 2'd0;
        check("t4_rwl", 32'(rwl_a), 32'h2);
        check("t4_ready_wl", 32'(bus_a.rd_ready), 32'd0);
        @(negedge clk);
        check("t4_valid", 32'({bus_a.rd_ready, bus_a.rd_valid, bus_a.rd_data}), 32'h7);
        @(negedge clk);
        check("t4_no_queue", 32'({bus_a.rd_ready, pre_a, rwl_a, bus_a.rd_valid}), 32'h40);
        @(negedge clk);
        check("t4_still_idle", 32'({pre_a, rwl_a}), 32'h0);

        // Asynchronous reset during the word-line phase
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 2'd1;
        @(negedge clk);
        bus_a.rd_req = 1'b0;
        check("t5_pre", 32'(pre_a), 32'd1);
        @(negedge clk);
        check("t5_rwl1", 32'(rwl_a), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rwl_async", 32'(rwl_a), 32'h0);
        check("t5_pre_async", 32'(pre_a), 32'd0);
        check("t5_state_async", 32'(st_a), 32'(IDLE));
        @(negedge clk);
        check("t5_no_capture", 32'({bus_a.rd_valid, bus_a.rd_data}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready", 32'({bus_a.rd_ready, bus_a.rd_valid}), 32'h2);
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 2'd3;
        @(negedge clk);
        bus_a.rd_req = 1'b0;
        check("t5_re_pre", 32'(pre_a), 32'd1);
        @(negedge clk);
        check("t5_re_rwl3", 32'(rwl_a), 32'h8);
        @(negedge clk);
        check("t5_re_valid", 32'({bus_a.rd_valid, bus_a.rd_data}), 32'h3);

        // Random traffic; rows change every cycle so capture timing is exercised
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int r = 0; r < 4; r++) rows[r] = DW'($urandom_range(0, 1));
            bus_a.rd_req  = ($urandom_range(0, 3) != 0);
            bus_a.rd_addr = 2'($urandom_range(0, 3));
            bus_b.rd_req  = ($urandom_range(0, 2) != 0);
            bus_b.rd_addr = 2'($urandom_range(0, 3));
        end
        bus_a.rd_req = 1'b0;
        bus_b.rd_req = 1'b0;
        repeat (10) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("sb_reads_seen", 32'(reads_done > 300), 32'd1);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/read_wl_ctrl.md
Name: read_wl_ctrl

Overview:
Upstream sequencer for the 4-row read_mux. It accepts a read request and 2-bit row address over a ready/req handshake, then drives a precharge phase. It then drives exactly one registered read word line (rwl_0..rwl_3), samples the mux output DOUT at the end of the word-line phase, and returns the captured data with a one-cycle valid pulse.

Parameters:
DATA_W, 1, number of parallel read_mux outputs captured per access (width of dout_in / rd_data).
PRE_CYCLES, 1, cycles precharge is held high before the word line fires (legal range 1..15).
WL_CYCLES, 1, cycles the selected word line is held high before sampling (legal range 1..15).

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
rd_req  input  1  read request; accepted on a rising edge when rd_ready=1.
rd_addr  input  2  row select, sampled with the accepted request.
rd_ready  output  1  high only in IDLE.
precharge  output  1  registered; high during the PRE phase.
rwl_0  output  1  registered word line for row 0 (to read_mux).
rwl_1  output  1  word line for row 1.
rwl_2  output  1  word line for row 2.
rwl_3  output  1  word line for row 3.
dout_in  input  DATA_W  DOUT from the read_mux instance(s).
rd_data  output  DATA_W  captured read data; held until the next capture.
rd_valid  output  1  one-cycle pulse; rd_data is new in this cycle.

Behaviour:
- Reset (async assert, sync-safe deassert via clk): state=IDLE, rd_ready=1, precharge=0, rwl_0..3=0, rd_data=0, rd_valid=0, counter=0. Reset asserted mid-access clears all word lines and precharge immediately, with no capture.
- States: IDLE, PRE, WL.
  - IDLE: rd_ready=1. On the edge where rd_req=1, latch rd_addr, load the counter with PRE_CYCLES-1, set precharge=1, and go to PRE.
  - PRE: precharge=1. Count down. At count 0: precharge<=0, assert the rwl selected by the latched address, load the counter with WL_CYCLES-1, and go to WL.
  - WL: exactly one rwl is high. Count down. At count 0: rd_data<=dout_in, rd_valid<=1, all rwl<=0, and go to IDLE.
- rd_valid is high for exactly one cycle, which is the first IDLE cycle after WL. It is 0 in all other cycles.
- Latency: rd_valid is high in the cycle beginning PRE_CYCLES+WL_CYCLES edges after the accept edge. Defaults give 2.
- Back-to-back: a request present during the rd_valid cycle is accepted at the next edge. The sustained throughput is therefore one access per PRE_CYCLES+WL_CYCLES+1 cycles.
- rd_req while rd_ready=0 is ignored and not queued. rd_addr changes outside the accept edge have no effect.
- Invariants, checked by assertion in every cycle:
  - At most one of rwl_0..3 is high.
  - No rwl is high while precharge=1.
  - No rwl is high outside WL.
  - All word-line and precharge outputs come directly from flops (glitch-free).
- The counter is 4 bits. Parameters outside 1..15 trigger an elaboration-time $error.
- dout_in is sampled only on the final WL edge. Its value at any other time is don't-care.

Decomposition:
- Package read_path_pkg holds:
  - NUM_ROWS=4 and ADDR_W=2.
  - The state enum {IDLE, PRE, WL}.
  - CNT_W=4.
- Sub-module rwl_decoder: registered 2-to-4 one-hot decoder with enable and synchronous clear, which drives rwl_0..3. It has the same clk/rst_n.
- The FSM, counter, and capture register live in read_wl_ctrl.

Test Plan:
1. Reset with defaults, rows preset in_0..3 = 1,1,0,1, rd_req=1 with rd_addr=0:
   - precharge is high for 1 cycle, then rwl_0 is high for 1 cycle.
   - rd_valid=1 with rd_data=1 two cycles after the accept edge.
2. Back-to-back addresses 1, 2, 3 with rd_req held high:
   - rwl_1, rwl_2, rwl_3 fire in order, each preceded by precharge.
   - rd_data sequence is 1, 0, 1.
   - Accepts are spaced 3 cycles apart.
3. PRE_CYCLES=3, WL_CYCLES=2, rd_addr=2:
   - precharge is high for exactly 3 cycles, then rwl_2 for 2 cycles.
   - rd_valid appears 5 cycles after accept with rd_data=0.
4. rd_req pulsed with rd_addr=3 during PRE of an addr-1 access:
   - The pulse is ignored; only rwl_1 fires.
   - rd_ready stays 0 until the rd_valid cycle.
5. rst_n asserted during WL with rwl_1 high:
   - rwl_1 and precharge drop to 0 asynchronously, before the next edge.
   - rd_valid stays 0 and rd_data=0.
   - After release, rd_ready=1 and a new access completes normally.
6. Random requests and addresses over 2000 cycles:
   - The one-hot rwl and precharge-exclusion assertions never fire.
   - Each rd_data equals the preset value of the addressed row.
